// File: rtl/scg_opcode_ctrl.sv
// SDRAM opcode controller: power-up init, single/burst read/write, self-refresh and auto-refresh
// sequencing toward the timing sequencer. Define SCG_AUTO_REF_EN to enable the internal refresh timer.
module scg_opcode_ctrl #(
  parameter int BURST_LEN    = 4,
  parameter int REF_INTERVAL = 780,
  parameter int INIT_WAIT    = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  input  logic [2:0] opcode,
  output logic       op_ready,
  input  logic       done,
  output logic [3:0] select,
  output logic       idle,
  output logic       init_done,
  output logic       ref_pending,
  output logic [3:0] beat_cnt
);

  localparam logic [4:0] I_WAIT  = 5'd0;
  localparam logic [4:0] I_PALL  = 5'd1;
  localparam logic [4:0] I_AR1   = 5'd2;
  localparam logic [4:0] I_AR2   = 5'd3;
  localparam logic [4:0] I_LMR   = 5'd4;
  localparam logic [4:0] READY   = 5'd5;
  localparam logic [4:0] SR_PALL = 5'd6;
  localparam logic [4:0] SR_ENT  = 5'd7;
  localparam logic [4:0] SR_HOLD = 5'd8;
  localparam logic [4:0] SR_EXIT = 5'd9;
  localparam logic [4:0] AREF    = 5'd10;
  localparam logic [4:0] RD_ACT  = 5'd11;
  localparam logic [4:0] RD_BEAT = 5'd12;
  localparam logic [4:0] RD_PRE  = 5'd13;
  localparam logic [4:0] WR_ACT  = 5'd14;
  localparam logic [4:0] WR_BEAT = 5'd15;
  localparam logic [4:0] WR_PRE  = 5'd16;

  localparam logic [3:0] CMD_NOP   = 4'd0;
  localparam logic [3:0] CMD_ACT   = 4'd1;
  localparam logic [3:0] CMD_RD    = 4'd2;
  localparam logic [3:0] CMD_RDB   = 4'd3;
  localparam logic [3:0] CMD_WR    = 4'd4;
  localparam logic [3:0] CMD_WRB   = 4'd5;
  localparam logic [3:0] CMD_AREF  = 4'd6;
  localparam logic [3:0] CMD_SRE   = 4'd7;
  localparam logic [3:0] CMD_SRX   = 4'd8;
  localparam logic [3:0] CMD_PALL  = 4'd9;
  localparam logic [3:0] CMD_LMR   = 4'd10;
  localparam logic [3:0] CMD_PRE   = 4'd11;

  localparam int             IW        = $clog2(INIT_WAIT + 1);
  localparam logic [IW-1:0]  INIT_LAST = IW'(INIT_WAIT - 1);
  localparam logic [3:0]     BEAT_LAST = 4'(BURST_LEN - 1);

  logic [4:0]    state;
  logic [IW-1:0] init_cnt;
  logic          burst_q;
  logic          accept;
  logic          last_beat;

  assign accept    = op_valid && op_ready;
  assign last_beat = !burst_q || (beat_cnt == BEAT_LAST);
  assign idle      = (state == READY);

  // Registered ref_pending gates READY acceptance, so op_ready never loops back through the FSM.
  always_comb begin
    // NOTE: default first so every path assigns op_ready and no latch is inferred.
    op_ready = 1'b0;
    if (state == READY)        op_ready = !ref_pending;
    else if (state == SR_HOLD) op_ready = (opcode == 3'd0);
  end

  always_comb begin
    select = CMD_NOP;
    case (state)
      I_PALL, SR_PALL: select = CMD_PALL;
      I_AR1, I_AR2:    select = CMD_AREF;
      I_LMR:           select = CMD_LMR;
      SR_ENT:          select = CMD_SRE;
      SR_EXIT:         select = CMD_SRX;
      AREF:            select = CMD_AREF;
      RD_ACT, WR_ACT:  select = CMD_ACT;
      RD_BEAT:         select = burst_q ? CMD_RDB : CMD_RD;
      WR_BEAT:         select = burst_q ? CMD_WRB : CMD_WR;
      RD_PRE, WR_PRE:  select = CMD_PRE;
      default:         select = CMD_NOP;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= I_WAIT;
      init_cnt  <= '0;
      beat_cnt  <= '0;
      burst_q   <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        I_WAIT: begin
          if (init_cnt == INIT_LAST) begin
            init_cnt <= '0;
            state    <= I_PALL;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        I_PALL: if (done) state <= I_AR1;
        I_AR1:  if (done) state <= I_AR2;
        I_AR2:  if (done) state <= I_LMR;
        I_LMR: begin
          if (done) begin
            state     <= READY;
            init_done <= 1'b1;
          end
        end
        READY: begin
          if (accept) begin
            burst_q <= opcode[0];
            case (opcode)
              3'd1: begin
                state     <= I_WAIT;
                init_done <= 1'b0;
              end
              3'd2:       state <= SR_PALL;
              3'd3:       state <= AREF;
              3'd4, 3'd5: state <= RD_ACT;
              3'd6, 3'd7: state <= WR_ACT;
              default:    state <= READY;
            endcase
          end else if (ref_pending) begin
            state <= AREF;
          end
        end
        SR_PALL: if (done)   state <= SR_ENT;
        SR_ENT:  if (done)   state <= SR_HOLD;
        SR_HOLD: if (accept) state <= SR_EXIT;
        SR_EXIT: if (done)   state <= READY;
        AREF:    if (done)   state <= READY;
        RD_ACT:  if (done)   state <= RD_BEAT;
        WR_ACT:  if (done)   state <= WR_BEAT;
        RD_BEAT, WR_BEAT: begin
          if (done) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) state <= (state == RD_BEAT) ? RD_PRE : WR_PRE;
          end
        end
        RD_PRE, WR_PRE: begin
          if (done) begin
            state    <= READY;
            beat_cnt <= '0;
          end
        end
        default: state <= I_WAIT;
      endcase
    end
  end

`ifdef SCG_AUTO_REF_EN
  localparam int            RW       = $clog2(REF_INTERVAL);
  localparam logic [RW-1:0] REF_LAST = RW'(REF_INTERVAL - 1);

  logic [RW-1:0] ref_timer;
  logic          in_sr;

  assign in_sr = (state == SR_PALL) || (state == SR_ENT) ||
                 (state == SR_HOLD) || (state == SR_EXIT);

  // Timer saturates at its last value; ref_pending stays set until an AREF completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_timer   <= '0;
      ref_pending <= 1'b0;
    end else if (state == AREF && done) begin
      ref_timer   <= '0;
      ref_pending <= 1'b0;
    end else if ((state == SR_EXIT && done) || (state == READY && accept && opcode == 3'd1)) begin
      ref_timer <= '0;
    end else if (init_done && !in_sr) begin
      if (ref_timer == REF_LAST) ref_pending <= 1'b1;
      else                       ref_timer   <= ref_timer + 1'b1;
    end
  end
`else
  assign ref_pending = 1'b0;
`endif

endmodule

// File: tb/tb_scg_opcode_ctrl.sv
// Self-checking bench for scg_opcode_ctrl: randomized done spacing and opcodes against a
// command-list reference model. Honours SCG_AUTO_REF_EN the same way the design does.
module tb_scg_opcode_ctrl;

  localparam int BURST_LEN    = 4;
  localparam int REF_INTERVAL = 20;
  localparam int INIT_WAIT    = 100;
`ifdef SCG_AUTO_REF_EN
  localparam int GAP_MAX = 1;
`else
  localparam int GAP_MAX = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       op_valid = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       done = 1'b0;
  logic       op_ready, idle, init_done, ref_pending;
  logic [3:0] select, beat_cnt;

  int errors = 0;
  int checks = 0;
  int exp_sel[$];
  int exp_beat[$];
  bit exp_init = 1'b0;
  bit exp_pend = 1'b0;

  always #5 clk = ~clk;

  scg_opcode_ctrl #(
    .BURST_LEN   (BURST_LEN),
    .REF_INTERVAL(REF_INTERVAL),
    .INIT_WAIT   (INIT_WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .opcode     (opcode),
    .op_ready   (op_ready),
    .done       (done),
    .select     (select),
    .idle       (idle),
    .init_done  (init_done),
    .ref_pending(ref_pending),
    .beat_cnt   (beat_cnt)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  // Reference model: the command list an opcode must produce, with the beat index per step (-1 = n/a).
  function automatic void push(input int s, input int b);
    exp_sel.push_back(s);
    exp_beat.push_back(b);
  endfunction

  function automatic void build(input int op);
    int n;
    int code;
    exp_sel.delete();
    exp_beat.delete();
    case (op)
      2: begin push(9, -1); push(7, -1); end
      3: push(6, -1);
      4, 5, 6, 7: begin
        n    = (op % 2 == 1) ? BURST_LEN : 1;
        code = ((op >= 6) ? 4 : 2) + (op % 2);
        push(1, -1);
        for (int b = 0; b < n; b++) push(code, b);
        push(11, -1);
      end
      default: ;
    endcase
  endfunction

  task automatic cyc();
    @(negedge clk);
    done = 1'b0;
  endtask

  // Walk the expected command list, pulsing done after a random number of cycles per command.
  task automatic run_seq(input string tag);
    int gap;
    foreach (exp_sel[i]) begin
      gap = $urandom_range(0, GAP_MAX);
      for (int c = 0; c <= gap; c++) begin
        cyc();
        op_valid = 1'($urandom_range(0, 1));
        opcode   = 3'($urandom_range(0, 7));
        #1;
        checks++;
        if (select !== 4'(exp_sel[i])) begin
          errors++;
          $display("FAIL %s select step %0d: got %0d want %0d", tag, i, select, exp_sel[i]);
        end
        checks++;
        if (op_ready !== 1'b0 || idle !== 1'b0) begin
          errors++;
          $display("FAIL %s busy flags step %0d: got op_ready=%b idle=%b want 0 0", tag, i, op_ready, idle);
        end
        checks++;
        if (init_done !== exp_init || ref_pending !== exp_pend) begin
          errors++;
          $display("FAIL %s status step %0d: got init_done=%b ref_pending=%b want %b %b",
                   tag, i, init_done, ref_pending, exp_init, exp_pend);
        end
        if (exp_beat[i] >= 0) begin
          checks++;
          if (beat_cnt !== 4'(exp_beat[i])) begin
            errors++;
            $display("FAIL %s beat_cnt step %0d: got %0d want %0d", tag, i, beat_cnt, exp_beat[i]);
          end
        end
        if (c == gap) done = 1'b1;
      end
    end
  endtask

  // I_WAIT must hold select=0 for INIT_WAIT cycles (done ignored), then PALL, AREF, AREF, LMR.
  task automatic run_init(input int taken, input string tag);
    exp_init = 1'b0;
    for (int k = taken + 1; k <= INIT_WAIT; k++) begin
      cyc();
      op_valid = 1'($urandom_range(0, 1));
      done     = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (select !== 4'd0 || idle !== 1'b0 || op_ready !== 1'b0 || init_done !== 1'b0) begin
        errors++;
        $display("FAIL %s init wait cycle %0d: got select=%0d idle=%b op_ready=%b init_done=%b want 0 0 0 0",
                 tag, k, select, idle, op_ready, init_done);
      end
    end
    exp_sel.delete();
    exp_beat.delete();
    push(9, -1); push(6, -1); push(6, -1); push(10, -1);
    run_seq({tag, "_init"});
    exp_init = 1'b1;
  endtask

  // Samples the first cycle after a reset edge, then runs the whole init sequence.
  task automatic reset_check(input string tag);
    cyc();
    rst      = 1'b0;
    op_valid = 1'b0;
    #1;
    checks++;
    if (select !== 4'd0 || beat_cnt !== 4'd0 || idle !== 1'b0 || op_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s reset outputs: got select=%0d beat_cnt=%0d idle=%b op_ready=%b want 0 0 0 0",
               tag, select, beat_cnt, idle, op_ready);
    end
    checks++;
    if (init_done !== 1'b0 || ref_pending !== 1'b0) begin
      errors++;
      $display("FAIL %s reset flags: got init_done=%b ref_pending=%b want 0 0", tag, init_done, ref_pending);
    end
    run_init(1, tag);
  endtask

  task automatic accept(input int op, input string tag);
    cyc();
    op_valid = 1'b1;
    opcode   = 3'(op);
    #1;
    checks++;
    if (idle !== 1'b1 || op_ready !== 1'b1 || select !== 4'd0 || beat_cnt !== 4'd0 ||
        init_done !== 1'b1 || ref_pending !== 1'b0) begin
      errors++;
      $display("FAIL %s ready: got idle=%b op_ready=%b select=%0d beat=%0d init=%b pend=%b want 1 1 0 0 1 0",
               tag, idle, op_ready, select, beat_cnt, init_done, ref_pending);
    end
  endtask

  task automatic sr_hold(input string tag);
    int h;
    h = $urandom_range(2, 5);
    for (int i = 0; i < h; i++) begin
      cyc();
      op_valid = 1'b1;
      opcode   = (i == 0) ? 3'd1 : 3'($urandom_range(1, 7));
      done     = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (select !== 4'd0 || op_ready !== 1'b0 || idle !== 1'b0) begin
        errors++;
        $display("FAIL %s sr hold %0d: got select=%0d op_ready=%b idle=%b want 0 0 0",
                 tag, i, select, op_ready, idle);
      end
    end
    cyc();
    op_valid = 1'b1;
    opcode   = 3'd0;
    #1;
    checks++;
    if (op_ready !== 1'b1 || select !== 4'd0) begin
      errors++;
      $display("FAIL %s sr exit request: got op_ready=%b select=%0d want 1 0", tag, op_ready, select);
    end
  endtask

  task automatic do_op(input int op, input string tag);
    build(op);
    accept(op, tag);
    if (op == 1) begin
      run_init(0, tag);
    end else begin
      run_seq(tag);
      if (op == 2) begin
        sr_hold(tag);
        exp_sel.delete();
        exp_beat.delete();
        push(8, -1);
        run_seq({tag, "_srx"});
      end
    end
  endtask

  // With the timer enabled, an explicit refresh first keeps later sequences clear of timer expiry.
  task automatic prep();
`ifdef SCG_AUTO_REF_EN
    do_op(3, "prep");
`endif
  endtask

  task automatic test_reset_init();
    reset_check("por");
  endtask

  task automatic test_auto_ref();
`ifdef SCG_AUTO_REF_EN
    for (int k = 1; k <= REF_INTERVAL; k++) begin
      cyc();
      op_valid = 1'b0;
      done     = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (idle !== 1'b1 || op_ready !== 1'b1 || ref_pending !== 1'b0) begin
        errors++;
        $display("FAIL aref wait %0d: got idle=%b op_ready=%b ref_pending=%b want 1 1 0",
                 k, idle, op_ready, ref_pending);
      end
    end
    cyc();
    op_valid = 1'b1;
    opcode   = 3'($urandom_range(0, 7));
    #1;
    checks++;
    if (idle !== 1'b1 || op_ready !== 1'b0 || ref_pending !== 1'b1) begin
      errors++;
      $display("FAIL aref pending: got idle=%b op_ready=%b ref_pending=%b want 1 0 1", idle, op_ready, ref_pending);
    end
    exp_pend = 1'b1;
    build(3);
    run_seq("aref_auto");
    exp_pend = 1'b0;
`else
    for (int k = 1; k <= 2 * REF_INTERVAL; k++) begin
      cyc();
      op_valid = 1'b0;
      done     = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (idle !== 1'b1 || op_ready !== 1'b1 || ref_pending !== 1'b0 || select !== 4'd0) begin
        errors++;
        $display("FAIL idle ready %0d: got idle=%b op_ready=%b ref_pending=%b select=%0d want 1 1 0 0",
                 k, idle, op_ready, ref_pending, select);
      end
    end
    do_op(3, "aref_op");
`endif
  endtask

`ifdef SCG_AUTO_REF_EN
  // Timer expires on the very edge an opcode is accepted: the opcode runs, then the refresh.
  task automatic test_ref_collision();
    prep();
    for (int k = 1; k < REF_INTERVAL; k++) begin
      cyc();
      op_valid = 1'b0;
      #1;
      checks++;
      if (ref_pending !== 1'b0) begin
        errors++;
        $display("FAIL collide wait %0d: got ref_pending=%b want 0", k, ref_pending);
      end
    end
    build(6);
    accept(6, "collide");
    exp_pend = 1'b1;
    run_seq("collide");
    cyc();
    op_valid = 1'b0;
    #1;
    checks++;
    if (idle !== 1'b1 || op_ready !== 1'b0 || ref_pending !== 1'b1) begin
      errors++;
      $display("FAIL collide ready: got idle=%b op_ready=%b ref_pending=%b want 1 0 1", idle, op_ready, ref_pending);
    end
    build(3);
    run_seq("collide_aref");
    exp_pend = 1'b0;
  endtask
`endif

  task automatic test_burst_read();
    prep();
    do_op(5, "rd_burst");
  endtask

  task automatic test_single_write();
    prep();
    do_op(6, "wr_single");
  endtask

  task automatic test_self_refresh();
    prep();
    do_op(2, "self_ref");
  endtask

  task automatic test_back_to_back();
    int op;
    for (int n = 0; n < 16; n++) begin
      op = $urandom_range(0, 7);
      prep();
      do_op(op, $sformatf("b2b%0d_op%0d", n, op));
    end
  endtask

  task automatic test_reset_mid_burst();
    prep();
    build(5);
    accept(5, "mid");
    while (exp_sel.size() > 3) begin
      void'(exp_sel.pop_back());
      void'(exp_beat.pop_back());
    end
    run_seq("mid");
    cyc();
    op_valid = 1'b0;
    #1;
    checks++;
    if (select !== 4'd3 || beat_cnt !== 4'd2) begin
      errors++;
      $display("FAIL mid beat2: got select=%0d beat_cnt=%0d want 3 2", select, beat_cnt);
    end
    rst  = 1'b1;
    done = 1'b1;
    reset_check("mid_rst");
    prep();
    do_op(4, "after_rst");
  endtask

  initial begin
    test_reset_init();
    test_auto_ref();
    test_burst_read();
    test_single_write();
    test_self_refresh();
`ifdef SCG_AUTO_REF_EN
    test_ref_collision();
`endif
    test_back_to_back();
    test_reset_mid_burst();
    cyc();
    op_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
